// File: rtl/rc_correct_exec.sv
// Sequential execution stage after the signed reverse-converter decoder.
// Each transaction computes (A op B) + G[sel], then shifts the result
// shamt times, one bit per cycle. The result is offered with valid/ready.
module rc_correct_exec #(
    parameter int unsigned n = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n:0]   a_in,
    input  logic [n:0]   b_in,
    input  logic [3:0]   aluOp,
    input  logic [2:0]   sel,
    input  logic [2:0]   shamt,
    input  logic         shdir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n+3:0] x_out,
    output logic         ovf,
    output logic         err,
    output logic         busy
);

    localparam int unsigned W = n + 4;

    localparam logic [W-1:0] One = W'(1);
    localparam logic [W-1:0] P1  = One << n;        // 2^n
    localparam logic [W-1:0] P2  = One << (n + 1);  // 2^(n+1)

    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;

    typedef enum logic [2:0] {StIdle, StAlu, StCorr, StShift, StDone} state_e;

    state_e       state_q, state_d;
    logic [n:0]   a_q, a_d;
    logic [n:0]   b_q, b_d;
    logic [3:0]   op_q, op_d;
    logic [2:0]   sel_q, sel_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         dir_q, dir_d;
    logic [W-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;

    logic [W-1:0] a_ext, b_ext, g_val;

    assign a_ext = {{3{a_q[n]}}, a_q};
    assign b_ext = {{3{b_q[n]}}, b_q};

    // Correction constant lookup; all values taken modulo 2^(n+4).
    always_comb begin
        g_val = '0;
        case (sel_q)
            3'd1:    g_val = P1;
            3'd2:    g_val = '0 - P1;
            3'd3:    g_val = P2;
            3'd4:    g_val = '0 - P2;
            3'd5:    g_val = P1 - One;
            3'd6:    g_val = One - P1;
            3'd7:    g_val = P2 - One;
            default: g_val = '0;
        endcase
    end

    // Next-state and datapath updates for the five-phase sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = aluOp;
                    sel_d   = sel;
                    cnt_d   = shamt;
                    dir_d   = shdir;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StAlu;
                end
            end
            StAlu: begin
                case (op_q)
                    OpAdd:   acc_d = a_ext + b_ext;
                    OpSub:   acc_d = a_ext - b_ext;
                    default: begin
                        // Illegal op still runs the full sequence from zero.
                        acc_d = '0;
                        err_d = 1'b1;
                    end
                endcase
                state_d = StCorr;
            end
            StCorr: begin
                acc_d   = acc_q + g_val;
                state_d = (cnt_q != 3'd0) ? StShift : StDone;
            end
            StShift: begin
                if (dir_q) begin
                    acc_d = {acc_q[W-1], acc_q[W-1:1]};
                end else begin
                    // Top two bits differing means the sign is lost by this shift.
                    if (acc_q[W-1] != acc_q[W-2]) begin
                        ovf_d = 1'b1;
                    end
                    acc_d = {acc_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from state or taken straight from registers.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        x_out     = acc_q;
        ovf       = ovf_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_rc_correct_exec.sv
// Self-checking bench for rc_correct_exec: directed table, reset-in-shift
// sequence, and randomized transactions against an integer reference model.
module tb_rc_correct_exec;

    localparam int N = 3;
    localparam int W = N + 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N:0]   a_in = '0;
    logic [N:0]   b_in = '0;
    logic [3:0]   aluOp = '0;
    logic [2:0]   sel = '0;
    logic [2:0]   shamt = '0;
    logic         shdir = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] x_out;
    logic         ovf;
    logic         err;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    rc_correct_exec #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .aluOp     (aluOp),
        .sel       (sel),
        .shamt     (shamt),
        .shdir     (shdir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .ovf       (ovf),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [2:0] sel;
        logic [2:0] shamt;
        logic       dir;
        int         x;
        bit         o;
        bit         e;
        int         stall;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int xs();
        return int'($signed(x_out));
    endfunction

    // Reduce an integer to the signed range of the W-bit result.
    function automatic int wrap(input int v);
        int m = 1 << W;
        int r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] op, input logic [2:0] s,
                                  input logic [2:0] sh, input logic dir,
                                  output int x, output bit o, output bit e);
        int p = 1 << N;
        int g[8] = '{0, p, -p, 2 * p, -2 * p, p - 1, 1 - p, 2 * p - 1};
        int va = int'($signed(a));
        int vb = int'($signed(b));
        int v;
        int lim = 1 << (W - 2);
        e = 1'b0;
        o = 1'b0;
        if (op == 4'b0010) v = va + vb;
        else if (op == 4'b0110) v = va - vb;
        else begin
            v = 0;
            e = 1'b1;
        end
        v = wrap(v + g[s]);
        for (int i = 0; i < int'(sh); i++) begin
            if (dir) begin
                v = v >>> 1;
            end else begin
                if (v < -lim || v >= lim) o = 1'b1;
                v = wrap(2 * v);
            end
        end
        x = v;
    endfunction

    // One full transaction: offer, wait for result, optional stall, handshake.
    task automatic run_txn(input string name, input vec_t t);
        int lat = 0;
        @(negedge clk);
        check({name, ".in_ready"}, int'(in_ready), 1);
        a_in     = t.a;
        b_in     = t.b;
        aluOp    = t.op;
        sel      = t.sel;
        shamt    = t.shamt;
        shdir    = t.dir;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = 4'($urandom);
        b_in     = 4'($urandom);
        aluOp    = 4'($urandom);
        sel      = 3'($urandom);
        shamt    = 3'($urandom);
        shdir    = 1'($urandom);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".latency"}, lat, 2 + int'(t.shamt));
        check({name, ".x_out"}, xs(), t.x);
        check({name, ".ovf"}, int'(ovf), int'(t.o));
        check({name, ".err"}, int'(err), int'(t.e));
        for (int i = 0; i < t.stall; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in     = 4'($urandom);
            b_in     = 4'($urandom);
            shamt    = 3'($urandom);
            @(posedge clk);
            #1;
            check({name, ".stall_valid"}, int'(out_valid), 1);
            check({name, ".stall_x"}, xs(), t.x);
            check({name, ".stall_ovf"}, int'(ovf), int'(t.o));
            check({name, ".stall_ready"}, int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, ".idle_ready"}, int'(in_ready), 1);
        check({name, ".idle_valid"}, int'(out_valid), 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{4'd5,  4'd3, 4'b0010, 3'd0, 3'd1, 1'b1,  4, 1'b0, 1'b0, 0};
        tbl[1] = '{4'hD,  4'd1, 4'b0010, 3'd3, 3'd1, 1'b1,  7, 1'b0, 1'b0, 1};
        tbl[2] = '{4'd2,  4'd6, 4'b0110, 3'd4, 3'd2, 1'b1, -5, 1'b0, 1'b0, 0};
        tbl[3] = '{4'd7,  4'd7, 4'b0010, 3'd3, 3'd2, 1'b0, -8, 1'b1, 1'b0, 2};
        tbl[4] = '{4'd1,  4'd1, 4'b0010, 3'd7, 3'd0, 1'b1, 17, 1'b0, 1'b0, 5};
        tbl[5] = '{4'd3,  4'd2, 4'b1111, 3'd1, 3'd0, 1'b0,  8, 1'b0, 1'b1, 0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.in_ready", int'(in_ready), 1);
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.x_out", xs(), 0);
        check("reset.ovf", int'(ovf), 0);
        check("reset.err", int'(err), 0);

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("dir%0d", i), tbl[i]);
        end

        // Reset asserted while shifting: everything returns to idle at once.
        @(negedge clk);
        a_in = 4'd7; b_in = 4'd7; aluOp = 4'b0010; sel = 3'd3; shamt = 3'd7; shdir = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid.busy_before", int'(busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid.busy", int'(busy), 0);
        check("rstmid.out_valid", int'(out_valid), 0);
        check("rstmid.x_out", xs(), 0);
        check("rstmid.ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid.in_ready", int'(in_ready), 1);
        run_txn("after_rst", tbl[2]);

        for (int i = 0; i < 40; i++) begin
            vec_t t;
            int r = int'($urandom_range(0, 7));
            t.a     = 4'($urandom);
            t.b     = 4'($urandom);
            t.op    = (r == 0) ? 4'($urandom) : ((r % 2 == 1) ? 4'b0010 : 4'b0110);
            t.sel   = 3'($urandom);
            t.shamt = 3'($urandom);
            t.dir   = 1'($urandom);
            t.stall = int'($urandom_range(0, 2));
            model(t.a, t.b, t.op, t.sel, t.shamt, t.dir, t.x, t.o, t.e);
            run_txn($sformatf("rnd%0d", i), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
